// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma receive path.
package enigma_pkg;

    localparam int SYMB_W = 7;

    typedef logic signed [SYMB_W-1:0] symb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } rx_state_t;

    // One buffered entry: the symbol plus a flag marking the final symbol of a message
    typedef struct packed {
        logic  last;
        symb_t symb;
    } rx_entry_t;

endpackage

// File: rtl/enigma_sym_fifo.sv
// Synchronous FIFO for tagged coded symbols. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module enigma_sym_fifo
    import enigma_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [SYMB_W:0] din_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [SYMB_W:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [SYMB_W:0] mem [DEPTH];

    // Pointer advance; a push into a full FIFO is only requested alongside a pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because empty gates the head downstream
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr[AW-1:0]] <= din_i;
        end
    end

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_o  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/enigma_rx.sv
// Receive-side collector: counts the coded symbols of one message, buffers
// them, presents them over valid/ready, tags the last one and flags drops.
module enigma_rx
    import enigma_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     msg_start_i,
    input  logic [7:0]               symb_numb_i,
    input  logic                     symb_val_i,
    input  logic signed [SYMB_W-1:0] symbol_i,
    input  logic                     rd_rdy_i,
    output logic                     rd_val_o,
    output logic signed [SYMB_W-1:0] rd_symb_o,
    output logic                     rd_last_o,
    output logic                     busy_o,
    output logic                     msg_done_o,
    output logic                     ovf_o
);

    rx_state_t state;
    logic [7:0] exp_cnt;
    logic [7:0] rcv_cnt;
    logic       ovf;
    logic       done;

    logic       fifo_full;
    logic       fifo_empty;
    rx_entry_t  fifo_din;
    rx_entry_t  fifo_head;

    logic       beat;
    logic       beat_is_last;
    logic       pop;
    logic       push;
    logic       drop;

    assign beat         = (state == RECV) && symb_val_i;
    assign beat_is_last = ((rcv_cnt + 8'd1) == exp_cnt);
    assign pop          = !fifo_empty && rd_rdy_i;
    assign push         = beat && (!fifo_full || pop);
    assign drop         = beat && fifo_full && !pop;

    assign fifo_din.last = beat_is_last;
    assign fifo_din.symb = symbol_i;

    enigma_sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (fifo_din),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Message FSM: arm on start, count beats, then wait for the buffer to drain.
    // DRAIN holds one extra cycle so the completion pulse is seen while still busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            exp_cnt <= '0;
            rcv_cnt <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (msg_start_i) begin
                        exp_cnt <= symb_numb_i;
                        rcv_cnt <= '0;
                        ovf     <= 1'b0;
                        state   <= (symb_numb_i == 8'd0) ? DRAIN : RECV;
                    end
                end
                RECV: begin
                    if (symb_val_i) begin
                        rcv_cnt <= rcv_cnt + 8'd1;
                        if (drop) begin
                            ovf <= 1'b1;
                        end
                        if (beat_is_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                    end else if (fifo_empty) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rd_val_o   = !fifo_empty;
    assign rd_symb_o  = fifo_empty ? '0 : fifo_head.symb;
    assign rd_last_o  = !fifo_empty && fifo_head.last;
    assign busy_o     = (state != IDLE);
    assign msg_done_o = done;
    assign ovf_o      = ovf;

endmodule
